// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation result arbiter.
// Holds the result field widths, the motion-vector correction constants, the result record
// and the helpers that turn a raw engine motion vector into the corrected output vector.
package me_pkg;

    localparam int unsigned SAD_W     = 14;
    localparam int unsigned MV_W      = 4;
    localparam int unsigned MVO_W     = 5;
    localparam int          MV_X_OFS  = 2;
    localparam int          MV_Y_OFS  = 1;
    localparam int          MV_X_WRAP = 14;

    // Largest corrected x before it wraps back into the negative range.
    localparam logic signed [MVO_W-1:0] MV_X_MAX = 5'sd8;

    typedef struct packed {
        logic [SAD_W-1:0] sad;
        logic [MV_W-1:0]  mv_x;
        logic [MV_W-1:0]  mv_y;
    } me_res_t;

    function automatic logic [MVO_W-1:0] correct_mv_x(input logic [MV_W-1:0] mv_x);
        logic signed [MVO_W-1:0] ext;
        logic signed [MVO_W-1:0] sum;
        ext = signed'({mv_x[MV_W-1], mv_x});
        sum = ext + MVO_W'(MV_X_OFS);
        // Offset results past +8 fold back by the wrap distance instead.
        if (sum > MV_X_MAX) begin
            return ext - MVO_W'(MV_X_WRAP);
        end
        return sum;
    endfunction

    function automatic logic [MVO_W-1:0] correct_mv_y(input logic [MV_W-1:0] mv_y);
        logic signed [MVO_W-1:0] ext;
        ext = signed'({mv_y[MV_W-1], mv_y});
        return ext + MVO_W'(MV_Y_OFS);
    endfunction

endpackage

// File: rtl/me_result_arbiter_if.sv
// Bundle of engine result inputs, merged result handshake and status flags.
//   engine side : finish_a_cur<n>, min_sad<n>, mv_x<n>, mv_y<n> (n = 0, 1)
//   output side : out_valid/out_ready handshake with out_eng, out_seq, out_mv_x, out_mv_y, out_sad
//   status      : ovf0/ovf1 sticky drop flags, clr_ovf clear, busy
// slave is the arbiter's view, master is the view of whatever drives engines and consumer.
interface me_result_arbiter_if #(
    parameter int unsigned SEQ_W = 8
);
    import me_pkg::*;

    logic                    finish_a_cur0;
    logic [SAD_W-1:0]        min_sad0;
    logic [MV_W-1:0]         mv_x0;
    logic [MV_W-1:0]         mv_y0;
    logic                    finish_a_cur1;
    logic [SAD_W-1:0]        min_sad1;
    logic [MV_W-1:0]         mv_x1;
    logic [MV_W-1:0]         mv_y1;

    logic                    out_valid;
    logic                    out_ready;
    logic                    out_eng;
    logic [SEQ_W-1:0]        out_seq;
    logic [MVO_W-1:0]        out_mv_x;
    logic [MVO_W-1:0]        out_mv_y;
    logic [SAD_W-1:0]        out_sad;

    logic                    ovf0;
    logic                    ovf1;
    logic                    clr_ovf;
    logic                    busy;

    modport slave (
        input  finish_a_cur0, min_sad0, mv_x0, mv_y0,
        input  finish_a_cur1, min_sad1, mv_x1, mv_y1,
        input  out_ready, clr_ovf,
        output out_valid, out_eng, out_seq, out_mv_x, out_mv_y, out_sad,
        output ovf0, ovf1, busy
    );

    modport master (
        output finish_a_cur0, min_sad0, mv_x0, mv_y0,
        output finish_a_cur1, min_sad1, mv_x1, mv_y1,
        output out_ready, clr_ovf,
        input  out_valid, out_eng, out_seq, out_mv_x, out_mv_y, out_sad,
        input  ovf0, ovf1, busy
    );

endinterface

// File: rtl/me_res_fifo.sv
// Synchronous result FIFO, one per engine.
//   clk, rst  : clock, asynchronous active-low reset
//   push_i    : write wdata_i; ignored when full (fullness taken before the edge)
//   pop_i     : advance read side; ignored when empty
//   rdata_o   : head entry, valid while !empty_o
//   full_o, empty_o : occupancy flags
module me_res_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PtrW+1)'(Depth));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i & ~full_o;
        do_pop   = pop_i & ~empty_o;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/me_result_arbiter.sv
// Merges results from two motion-estimation engines into one registered output stream.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : engine inputs, out_valid/out_ready result handshake, ovf/clr_ovf, busy
// Each engine result is tagged with a per-engine sequence number and buffered in its own FIFO;
// a round-robin arbiter feeds a single output register, applying motion-vector correction on load.
module me_result_arbiter #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SEQ_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    me_result_arbiter_if.slave bus
);
    import me_pkg::*;

    typedef struct packed {
        me_res_t          res;
        logic [SEQ_W-1:0] seq;
    } entry_t;

    localparam int unsigned EntryW = $bits(entry_t);

    entry_t           wr0, wr1, rd0, rd1, sel;
    logic             full0, full1, empty0, empty1;
    logic             pop0, pop1, load, gnt;

    logic [SEQ_W-1:0] seq0_q, seq0_d, seq1_q, seq1_d;
    logic             ovf0_q, ovf0_d, ovf1_q, ovf1_d;
    logic             last_q, last_d;
    logic             out_valid_q, out_valid_d;
    logic             out_eng_q, out_eng_d;
    logic [SEQ_W-1:0] out_seq_q, out_seq_d;
    logic [MVO_W-1:0] out_mv_x_q, out_mv_x_d;
    logic [MVO_W-1:0] out_mv_y_q, out_mv_y_d;
    logic [SAD_W-1:0] out_sad_q, out_sad_d;

    assign wr0 = '{res: '{sad: bus.min_sad0, mv_x: bus.mv_x0, mv_y: bus.mv_y0}, seq: seq0_q};
    assign wr1 = '{res: '{sad: bus.min_sad1, mv_x: bus.mv_x1, mv_y: bus.mv_y1}, seq: seq1_q};

    me_res_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (EntryW)
    ) u_fifo0 (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.finish_a_cur0),
        .pop_i   (pop0),
        .wdata_i (wr0),
        .rdata_o (rd0),
        .full_o  (full0),
        .empty_o (empty0)
    );

    me_res_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (EntryW)
    ) u_fifo1 (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.finish_a_cur1),
        .pop_i   (pop1),
        .wdata_i (wr1),
        .rdata_o (rd1),
        .full_o  (full1),
        .empty_o (empty1)
    );

    always_comb begin
        // Sequence numbers advance on every finish, including dropped ones.
        seq0_d = bus.finish_a_cur0 ? seq0_q + 1'b1 : seq0_q;
        seq1_d = bus.finish_a_cur1 ? seq1_q + 1'b1 : seq1_q;

        // Drop sets the flag; a simultaneous clear loses.
        ovf0_d = (bus.finish_a_cur0 & full0) | (ovf0_q & ~bus.clr_ovf);
        ovf1_d = (bus.finish_a_cur1 & full1) | (ovf1_q & ~bus.clr_ovf);

        // Round robin on a tie, otherwise whichever FIFO holds data.
        gnt = (!empty0 && !empty1) ? ~last_q : empty0;
        sel = gnt ? rd1 : rd0;

        load = (!out_valid_q || bus.out_ready) && (!empty0 || !empty1);
        pop0 = load & ~gnt;
        pop1 = load & gnt;

        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_eng_d   = out_eng_q;
        out_seq_d   = out_seq_q;
        out_mv_x_d  = out_mv_x_q;
        out_mv_y_d  = out_mv_y_q;
        out_sad_d   = out_sad_q;

        if (load) begin
            last_d      = gnt;
            out_valid_d = 1'b1;
            out_eng_d   = gnt;
            out_seq_d   = sel.seq;
            out_mv_x_d  = correct_mv_x(sel.res.mv_x);
            out_mv_y_d  = correct_mv_y(sel.res.mv_y);
            out_sad_d   = sel.res.sad;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq0_q      <= '0;
            seq1_q      <= '0;
            ovf0_q      <= 1'b0;
            ovf1_q      <= 1'b0;
            last_q      <= 1'b1;
            out_valid_q <= 1'b0;
            out_eng_q   <= 1'b0;
            out_seq_q   <= '0;
            out_mv_x_q  <= '0;
            out_mv_y_q  <= '0;
            out_sad_q   <= '0;
        end else begin
            seq0_q      <= seq0_d;
            seq1_q      <= seq1_d;
            ovf0_q      <= ovf0_d;
            ovf1_q      <= ovf1_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_eng_q   <= out_eng_d;
            out_seq_q   <= out_seq_d;
            out_mv_x_q  <= out_mv_x_d;
            out_mv_y_q  <= out_mv_y_d;
            out_sad_q   <= out_sad_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_eng   = out_eng_q;
    assign bus.out_seq   = out_seq_q;
    assign bus.out_mv_x  = out_mv_x_q;
    assign bus.out_mv_y  = out_mv_y_q;
    assign bus.out_sad   = out_sad_q;
    assign bus.ovf0      = ovf0_q;
    assign bus.ovf1      = ovf1_q;
    assign bus.busy      = out_valid_q | ~empty0 | ~empty1;

endmodule

// File: tb/tb_me_result_arbiter.sv
// Directed bench for me_result_arbiter: latency, mv correction, round robin, overflow, stall/reset.
module tb_me_result_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    me_result_arbiter_if #(.SEQ_W(8)) bus ();

    me_result_arbiter #(
        .FIFO_DEPTH (4),
        .SEQ_W      (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic pulse0(input logic [13:0] sad, input logic [3:0] x, input logic [3:0] y);
        bus.finish_a_cur0 = 1'b1;
        bus.min_sad0      = sad;
        bus.mv_x0         = x;
        bus.mv_y0         = y;
        tick();
        bus.finish_a_cur0 = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (bus.out_valid) break;
            tick();
        end
        check("wait_valid", 32'(bus.out_valid), 32'd1);
    endtask

    logic [0:5] exp_eng;
    logic [7:0] exp_seq [6];
    int         n_got;
    int         first_i;

    initial begin
        bus.finish_a_cur0 = 1'b0;
        bus.min_sad0      = '0;
        bus.mv_x0         = '0;
        bus.mv_y0         = '0;
        bus.finish_a_cur1 = 1'b0;
        bus.min_sad1      = '0;
        bus.mv_x1         = '0;
        bus.mv_y1         = '0;
        bus.out_ready     = 1'b1;
        bus.clr_ovf       = 1'b0;

        // Reset state
        #3;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ovf0", 32'(bus.ovf0), 32'd0);
        check("rst_seq", 32'(bus.out_seq), 32'd0);
        check("rst_sad", 32'(bus.out_sad), 32'd0);
        do_reset();

        // Single result: mv (3,-2) -> (5,-1), two-edge latency
        pulse0(14'd100, 4'd3, 4'hE);
        check("lat_e_valid", 32'(bus.out_valid), 32'd0);
        check("lat_e_busy", 32'(bus.busy), 32'd1);
        tick();
        check("single_valid", 32'(bus.out_valid), 32'd1);
        check("single_eng", 32'(bus.out_eng), 32'd0);
        check("single_seq", 32'(bus.out_seq), 32'd0);
        check("single_mvx", 32'(bus.out_mv_x), 32'h05);
        check("single_mvy", 32'(bus.out_mv_y), 32'h1F);
        check("single_sad", 32'(bus.out_sad), 32'd100);
        tick();
        check("single_drain", 32'(bus.out_valid), 32'd0);
        check("single_idle", 32'(bus.busy), 32'd0);

        // Wrap cases
        pulse0(14'd9, 4'd7, 4'd7);
        wait_valid(4);
        check("wrap_mvx7", 32'(bus.out_mv_x), 32'h19);
        check("wrap_mvy7", 32'(bus.out_mv_y), 32'h08);
        check("wrap_seq1", 32'(bus.out_seq), 32'd1);
        tick();
        pulse0(14'd9, 4'h8, 4'd0);
        wait_valid(4);
        check("wrap_mvx_m8", 32'(bus.out_mv_x), 32'h1A);
        check("wrap_mvy0", 32'(bus.out_mv_y), 32'h01);
        tick();

        // Simultaneous finishes for 3 cycles -> alternate engines
        do_reset();
        exp_eng = 6'b010101;
        exp_seq = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2};
        bus.finish_a_cur0 = 1'b1;
        bus.min_sad0      = 14'd300;
        bus.mv_x0         = 4'd2;
        bus.mv_y0         = 4'hF;
        bus.finish_a_cur1 = 1'b1;
        bus.min_sad1      = 14'd200;
        bus.mv_x1         = 4'hF;
        bus.mv_y1         = 4'd0;
        n_got   = 0;
        first_i = -1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i == 2) begin
                bus.finish_a_cur0 = 1'b0;
                bus.finish_a_cur1 = 1'b0;
            end
            if (bus.out_valid && n_got < 6) begin
                if (first_i < 0) first_i = i;
                check($sformatf("rr_eng%0d", n_got), 32'(bus.out_eng), 32'(exp_eng[n_got]));
                check($sformatf("rr_seq%0d", n_got), 32'(bus.out_seq), 32'(exp_seq[n_got]));
                check($sformatf("rr_sad%0d", n_got), 32'(bus.out_sad),
                      exp_eng[n_got] ? 32'd200 : 32'd300);
                check($sformatf("rr_mvx%0d", n_got), 32'(bus.out_mv_x),
                      exp_eng[n_got] ? 32'h01 : 32'h04);
                check($sformatf("rr_b2b%0d", n_got), 32'(i), 32'(1 + n_got));
                n_got++;
            end
        end
        check("rr_count", 32'(n_got), 32'd6);
        check("rr_first", 32'(first_i), 32'd1);

        // Overflow: 6 pulses with out_ready low, depth 4
        do_reset();
        bus.out_ready     = 1'b0;
        bus.finish_a_cur0 = 1'b1;
        bus.min_sad0      = 14'd42;
        bus.mv_x0         = 4'd0;
        bus.mv_y0         = 4'd0;
        repeat (6) @(posedge clk);
        #1;
        bus.finish_a_cur0 = 1'b0;
        check("ovf_set0", 32'(bus.ovf0), 32'd1);
        check("ovf_clear1", 32'(bus.ovf1), 32'd0);
        check("ovf_head", 32'(bus.out_seq), 32'd0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("ovf_valid%0d", k), 32'(bus.out_valid), 32'd1);
            check($sformatf("ovf_seq%0d", k), 32'(bus.out_seq), 32'(k));
            tick();
        end
        check("ovf_empty", 32'(bus.out_valid), 32'd0);
        pulse0(14'd1, 4'd0, 4'd0);
        wait_valid(4);
        check("ovf_next_seq", 32'(bus.out_seq), 32'd6);
        check("ovf_sticky", 32'(bus.ovf0), 32'd1);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        check("ovf_cleared", 32'(bus.ovf0), 32'd0);
        tick();

        // Stall then asynchronous reset mid-stall
        do_reset();
        bus.out_ready = 1'b0;
        pulse0(14'd55, 4'd1, 4'd2);
        pulse0(14'd66, 4'd0, 4'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("stall_valid%0d", k), 32'(bus.out_valid), 32'd1);
            check($sformatf("stall_data%0d", k),
                  {bus.out_eng, bus.out_seq, bus.out_mv_x, bus.out_mv_y, bus.out_sad},
                  {1'b0, 8'd0, 5'd3, 5'd3, 14'd55});
            if (k < 3) tick();
        end
        rst = 1'b0;
        #1;
        check("stall_rst_valid", 32'(bus.out_valid), 32'd0);
        check("stall_rst_busy", 32'(bus.busy), 32'd0);
        #2;
        rst = 1'b1;
        tick();
        bus.out_ready = 1'b1;
        pulse0(14'd7, 4'd0, 4'd0);
        wait_valid(4);
        check("post_rst_seq", 32'(bus.out_seq), 32'd0);
        check("post_rst_sad", 32'(bus.out_sad), 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/me_result_arbiter.md
ME_RESULT_ARBITER -- requirements
Module: me_result_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, entries per engine result FIFO (power of two, >=2).
REQ-002 Parameter SEQ_W, default 8, width of per-engine block sequence number.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 finish_a_cur0  input  1  engine 0 result-valid pulse, one cycle per current block.
REQ-006 min_sad0  input  14  engine 0 minimum SAD, unsigned.
REQ-007 mv_x0 / mv_y0  input  4 each  engine 0 raw motion vector, signed two's complement.
REQ-008 finish_a_cur1, min_sad1, mv_x1, mv_y1  input  1/14/4/4  engine 1 equivalents.
REQ-009 out_valid  output  1  merged result available.
REQ-010 out_ready  input  1  downstream accepts result when high with out_valid.
REQ-011 out_eng  output  1  source engine of presented result.
REQ-012 out_seq  output  SEQ_W  source engine's block sequence number.
REQ-013 out_mv_x / out_mv_y  output  5 each  corrected motion vector, signed.
REQ-014 out_sad  output  14  min SAD of presented result.
REQ-015 ovf0 / ovf1  output  1 each  sticky drop flag per engine.
REQ-016 clr_ovf  input  1  synchronous clear of both ovf flags.
REQ-017 busy  output  1  high while any FIFO non-empty or out_valid high.

Function
REQ-018 On finish_a_cur<n>=1 at an edge, {min_sad, mv_x, mv_y, seq<n>} SHALL be pushed into FIFO n if FIFO n was not full before that edge; fullness is judged pre-edge even if a pop occurs same edge.
REQ-019 If FIFO n is full, the result SHALL be dropped and ovf<n> set at that edge; clr_ovf clears, set wins over simultaneous clr.
REQ-020 seq<n> SHALL increment (modulo 2^SEQ_W) on every finish pulse, dropped or not, wrapping 255->0 for SEQ_W=8.
REQ-021 Output register SHALL load from a granted FIFO when (!out_valid || out_ready) and at least one FIFO is non-empty; otherwise it holds all out_* stable.
REQ-022 Latency: finish at edge E with empty FIFO and idle output -> out_valid high after edge E+1.
REQ-023 Arbitration SHALL be round-robin: both non-empty -> grant engine other than last granted; one non-empty -> grant it; last-granted pointer resets to 1 so engine 0 wins first tie.
REQ-024 Simultaneous finish from both engines SHALL push both FIFOs in the same edge.
REQ-025 out_mv_x SHALL equal mv_x-14 if sext(mv_x)+2 > 8, else sext(mv_x)+2 (5-bit signed); out_mv_y SHALL equal sext(mv_y)+1.
REQ-026 Back-to-back transfer: with out_ready held high and data available, one result per cycle.
REQ-027 No combinational path from finish/out_ready to out_valid or out_* data.

Reset
REQ-028 rst low SHALL asynchronously clear FIFOs, pointers, seq counters (0), out_valid, out_eng, out_seq, out_mv_x, out_mv_y, out_sad (all 0), ovf0/ovf1 (0), busy (0), last-grant (1).
REQ-029 Reset mid-transfer SHALL discard all buffered and presented results; first post-reset result carries seq 0.

Structure
REQ-030 Shared package me_pkg SHALL hold SAD_W=14, MV_W=4, MVO_W=5, MV_X_OFS=2, MV_Y_OFS=1, MV_X_WRAP=14 and the result record typedef.
REQ-031 Sub-module me_res_fifo (synchronous, FIFO_DEPTH entries, full/empty flags) SHALL be instantiated once per engine.

Verification
REQ-032 Single result: finish0 with mv_x0=3, mv_y0=-2, sad=100, out_ready=1 -> out_valid after 2 edges with eng=0, seq=0, mv_x=5, mv_y=-1, sad=100.
REQ-033 Wrap: mv_x0=7, mv_y0=7 -> out_mv_x=-7, out_mv_y=8; mv_x0=-8 -> out_mv_x=-6.
REQ-034 Simultaneous finish0/finish1 for 3 cycles, out_ready=1 -> outputs alternate eng 0,1,0,1,0,1 with seq 0,0,1,1,2,2.
REQ-035 out_ready=0, 6 finish0 pulses (depth 4) -> ovf0=1, outputs then seq 0..4 (output reg + 4 FIFO), seq 5 lost, next pulse gets seq 6.
REQ-036 Stall: out_ready low 3 cycles with out_valid high -> all out_* stable; reset asserted mid-stall -> out_valid=0, busy=0 immediately.
